// File: rtl/cpu_types_pkg.sv
// Types shared between the CPU-side memory controller and the RAM model.
// ramstate_t is the status the RAM end reports back each cycle.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/ram_responder_pkg.sv
// Helpers local to the RAM responder: request legality against the array size.
package ram_responder_pkg;
    import cpu_types_pkg::*;

    // A request is illegal if it asks for both directions, is not word aligned,
    // or points past the last word of a 2^abits-word array.
    function automatic logic req_invalid(input logic ren, input logic wen,
                                         input word_t addr, input int unsigned abits);
        return (ren & wen) | (addr[1:0] != 2'b00) | ((addr >> (abits + 2)) != '0);
    endfunction

endpackage

// File: rtl/ram_responder_if.sv
// CPU-to-RAM bus: request fields from the controller, load data and status back.
interface ram_responder_if;
    cpu_types_pkg::word_t     ramaddr;
    cpu_types_pkg::word_t     ramstore;
    logic                     ramREN;
    logic                     ramWEN;
    cpu_types_pkg::word_t     ramload;
    cpu_types_pkg::ramstate_t ramstate;

    modport master (output ramaddr, ramstore, ramREN, ramWEN,
                    input  ramload, ramstate);
    modport slave  (input  ramaddr, ramstore, ramREN, ramWEN,
                    output ramload, ramstate);
endinterface

// File: rtl/ram_responder_array.sv
// Single-port word array with write enable and a registered read port.
// Contents are never reset; only the read register is.
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int ADDR_BITS = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  word_t                wdata,
    output word_t                rdata
);

    word_t mem [2**ADDR_BITS];
    word_t rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[addr];
    end

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Behavioural main-memory responder: one read or write at a time with
// LAT wait states, status reported on ramstate.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | FREE, sampling for a new request
//   ST_WAIT  | BUSY, counting wait states on a captured request
//   ST_DONE  | ACCESS, one cycle; write committed / read data on ramload
//   ST_FAULT | ERROR, held until the illegal request drops or turns legal
module ram_responder
    import cpu_types_pkg::*;
    import ram_responder_pkg::*;
#(
    parameter int LAT       = 2,
    parameter int ADDR_BITS = 14
) (
    input  logic         CLK,
    input  logic         RST,
    ram_responder_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [3:0] LAT_RELOAD = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    word_t      addr_q, addr_d;
    word_t      store_q, store_d;
    logic       ren_q, ren_d;
    logic       wen_q, wen_d;
    ramstate_t  ramstate_q, ramstate_d;

    logic req, bad, changed, capture, go_done, array_we;

    always_comb begin
        req     = bus.ramREN | bus.ramWEN;
        bad     = req_invalid(bus.ramREN, bus.ramWEN, bus.ramaddr, ADDR_BITS);
        changed = {addr_q, store_q, ren_q, wen_q} !=
                  {bus.ramaddr, bus.ramstore, bus.ramREN, bus.ramWEN};

        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        go_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (bad) begin
                        state_d = ST_FAULT;
                    end else if (LAT == 0) begin
                        state_d = ST_DONE;
                        go_done = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_RELOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (changed) begin
                    // Any change restarts the latency and re-runs the legality check.
                    capture = 1'b1;
                    cnt_d   = LAT_RELOAD;
                    if (bad) state_d = ST_FAULT;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    go_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: if (!(req && bad)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        addr_d  = capture ? bus.ramaddr  : addr_q;
        store_d = capture ? bus.ramstore : store_q;
        ren_d   = capture ? bus.ramREN   : ren_q;
        wen_d   = capture ? bus.ramWEN   : wen_q;

        case (state_d)
            ST_WAIT:  ramstate_d = BUSY;
            ST_DONE:  ramstate_d = ACCESS;
            ST_FAULT: ramstate_d = ERROR;
            default:  ramstate_d = FREE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            store_q    <= '0;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            ramstate_q <= FREE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            store_q    <= store_d;
            ren_q      <= ren_d;
            wen_q      <= wen_d;
            ramstate_q <= ramstate_d;
        end
    end

    // On entry to DONE the captured request equals the live inputs, so the
    // array is driven straight from the bus; reset blocks a same-edge commit.
    assign array_we = go_done & bus.ramWEN & ~RST;

    ram_array #(.ADDR_BITS(ADDR_BITS)) u_array (
        .clk   (CLK),
        .rst   (RST),
        .we    (array_we),
        .re    (go_done & bus.ramREN),
        .addr  (bus.ramaddr[ADDR_BITS+1:2]),
        .wdata (bus.ramstore),
        .rdata (bus.ramload)
    );

    assign bus.ramstate = ramstate_q;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: LAT=2 instance driven from a per-cycle vector table
// with a read-data scoreboard, plus a hand-written LAT=0 sequence.
module tb_ram_responder;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    ram_responder_if a_if();
    ram_responder_if b_if();

    ram_responder #(.LAT(2), .ADDR_BITS(14)) dut_a (.CLK(CLK), .RST(RST), .bus(a_if));
    ram_responder #(.LAT(0), .ADDR_BITS(14)) dut_b (.CLK(CLK), .RST(RST), .bus(b_if));

    typedef struct {
        logic      rst;
        logic      ren;
        logic      wen;
        word_t     addr;
        word_t     store;
        ramstate_t st;
        logic      push;
        logic      chk;
        word_t     d;
    } vec_t;

    vec_t  vecs[$];
    word_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic ren, input logic wen,
                                input word_t addr, input word_t store, input ramstate_t st,
                                input logic push, input logic chk, input word_t d);
        vec_t v;
        v.rst = rst; v.ren = ren; v.wen = wen; v.addr = addr; v.store = store;
        v.st = st; v.push = push; v.chk = chk; v.d = d;
        vecs.push_back(v);
    endfunction

    function automatic void txn_w(input word_t addr, input word_t data, input logic tail_idle);
        add(0, 0, 1, addr, data, FREE,   0, 0, 0);
        add(0, 0, 1, addr, data, BUSY,   0, 0, 0);
        add(0, 0, 1, addr, data, BUSY,   0, 0, 0);
        add(0, 0, 1, addr, data, ACCESS, 0, 0, 0);
        if (tail_idle) add(0, 0, 0, 0, 0, FREE, 0, 0, 0);
    endfunction

    // Read with the expected word pushed at issue; ramload must hold afterwards.
    function automatic void txn_r(input word_t addr, input word_t data);
        add(0, 1, 0, addr, 0, FREE,   1, 0, data);
        add(0, 1, 0, addr, 0, BUSY,   0, 0, 0);
        add(0, 1, 0, addr, 0, BUSY,   0, 0, 0);
        add(0, 1, 0, addr, 0, ACCESS, 0, 0, 0);
        add(0, 0, 0, 0,    0, FREE,   0, 1, data);
    endfunction

    function automatic void flt(input logic ren, input logic wen, input word_t addr);
        add(0, ren, wen, addr, 32'hBAD0BAD0, FREE,  0, 0, 0);
        add(0, ren, wen, addr, 32'hBAD0BAD0, ERROR, 0, 0, 0);
        add(0, ren, wen, addr, 32'hBAD0BAD0, ERROR, 0, 0, 0);
        add(0, 0,   0,   0,    0,            ERROR, 0, 0, 0);
        add(0, 0,   0,   0,    0,            FREE,  0, 0, 0);
    endfunction

    task automatic apply_a(input vec_t v, input int idx);
        word_t exp;
        @(negedge CLK);
        RST           = v.rst;
        a_if.ramREN   = v.ren;
        a_if.ramWEN   = v.wen;
        a_if.ramaddr  = v.addr;
        a_if.ramstore = v.store;
        if (v.push) sb.push_back(v.d);
        check($sformatf("a_row%0d_state", idx), 32'(a_if.ramstate), 32'(v.st));
        if (v.chk) check($sformatf("a_row%0d_load_hold", idx), a_if.ramload, v.d);
        if (a_if.ramstate == ACCESS && v.ren) begin
            if (sb.size() == 0) begin
                check($sformatf("a_row%0d_sb_unexpected_read", idx), 32'd1, 32'd0);
            end else begin
                exp = sb.pop_front();
                check($sformatf("a_row%0d_read_data", idx), a_if.ramload, exp);
            end
        end
    endtask

    task automatic step_b(input logic ren, input logic wen, input word_t addr, input word_t store,
                          input ramstate_t st, input logic chk, input word_t d, input string name);
        @(negedge CLK);
        b_if.ramREN   = ren;
        b_if.ramWEN   = wen;
        b_if.ramaddr  = addr;
        b_if.ramstore = store;
        check({name, "_state"}, 32'(b_if.ramstate), 32'(st));
        if (chk) check({name, "_load"}, b_if.ramload, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_if.ramREN = 0; a_if.ramWEN = 0; a_if.ramaddr = 0; a_if.ramstore = 0;
        b_if.ramREN = 0; b_if.ramWEN = 0; b_if.ramaddr = 0; b_if.ramstore = 0;

        // Reset state, then write and read back starting at cycle LAT+2.
        add(0, 0, 0, 0, 0, FREE, 0, 1, 32'h0);
        txn_w(32'h40, 32'hDEADBEEF, 0);
        txn_r(32'h40, 32'hDEADBEEF);
        txn_w(32'h80, 32'hA5A5A5A5, 1);
        // Restart: address moves to 0x84 in cycle 1, ACCESS lands in cycle 4.
        add(0, 0, 1, 32'h80, 32'h11111111, FREE,   0, 0, 0);
        add(0, 0, 1, 32'h84, 32'h11111111, BUSY,   0, 0, 0);
        add(0, 0, 1, 32'h84, 32'h11111111, BUSY,   0, 0, 0);
        add(0, 0, 1, 32'h84, 32'h11111111, BUSY,   0, 0, 0);
        add(0, 0, 1, 32'h84, 32'h11111111, ACCESS, 0, 0, 0);
        add(0, 0, 0, 0,      0,            FREE,   0, 0, 0);
        txn_r(32'h84, 32'h11111111);
        txn_r(32'h80, 32'hA5A5A5A5);
        // Abort: WEN dropped in cycle 1.
        add(0, 0, 1, 32'h40, 32'h12345678, FREE, 0, 0, 0);
        add(0, 0, 0, 0,      0,            BUSY, 0, 0, 0);
        add(0, 0, 0, 0,      0,            FREE, 0, 0, 0);
        txn_r(32'h40, 32'hDEADBEEF);
        // Illegal requests.
        flt(1, 1, 32'h40);
        flt(1, 0, 32'h42);
        flt(1, 0, 32'h0001_0000);
        txn_r(32'h40, 32'hDEADBEEF);
        // Reset in cycle 1 of a write to 0x84.
        add(0, 0, 1, 32'h84, 32'h77777777, FREE, 0, 0, 0);
        add(1, 0, 1, 32'h84, 32'h77777777, BUSY, 0, 0, 0);
        add(0, 0, 0, 0,      0,            FREE, 0, 1, 32'h0);
        txn_r(32'h84, 32'h11111111);
        txn_r(32'h40, 32'hDEADBEEF);

        repeat (3) @(negedge CLK);
        foreach (vecs[i]) apply_a(vecs[i], i);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL a_sb_drain: got %0d pending expected 0", sb.size());
        end

        // LAT=0: no BUSY, ACCESS one cycle after the request is sampled.
        step_b(0, 1, 32'h40, 32'hDEADBEEF, FREE,   0, 0, "b_w40_c0");
        step_b(0, 0, 32'h0,  32'h0,        ACCESS, 0, 0, "b_w40_c1");
        step_b(0, 1, 32'h44, 32'hCAFEF00D, FREE,   0, 0, "b_w44_c0");
        step_b(0, 0, 32'h0,  32'h0,        ACCESS, 0, 0, "b_w44_c1");
        step_b(1, 0, 32'h40, 32'h0,        FREE,   0, 0, "b_r40_c0");
        step_b(1, 0, 32'h40, 32'h0,        ACCESS, 1, 32'hDEADBEEF, "b_r40_c1");
        step_b(1, 0, 32'h44, 32'h0,        FREE,   1, 32'hDEADBEEF, "b_r44_c0");
        step_b(1, 0, 32'h44, 32'h0,        ACCESS, 1, 32'hCAFEF00D, "b_r44_c1");
        step_b(0, 0, 32'h0,  32'h0,        FREE,   1, 32'hCAFEF00D, "b_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
